// File: rtl/cla_seq_adder.sv
// Wide adder built from one 3-bit carry-lookahead slice reused once per clock.
// Operands are accepted and results returned over valid/ready handshakes.

module cla3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] s,
  output logic       cout
);
  logic [2:0] g, p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // All carries come straight from generate/propagate, with no rippling inside the slice
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[2:0];
  assign cout = c[3];
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / 3;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if ((WIDTH % 3) != 0 || WIDTH < 3) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a positive multiple of 3");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] opa, opb;
  logic [2:0]       slice_a, slice_b, slice_s;
  logic             slice_cout;

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Steer the current chunk of each operand onto the shared slice
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx == IW'(k)) begin
        slice_a = opa[3*k +: 3];
        slice_b = opb[3*k +: 3];
      end
    end
  end

  cla3 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            opa   <= in_a;
            opb   <= in_b;
            carry <= in_cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IW'(k)) out_sum[3*k +: 3] <= slice_s;
          end
          carry <= slice_cout;
          if (idx == LAST) begin
            out_cout <= slice_cout;
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: latency-based reference model checked every cycle,
// plus directed vectors with hand-computed sums.

module tb_cla_seq_adder;
  localparam int W = 12;
  localparam int N = W / 3;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: an accepted add shows its result N cycles later and holds it until taken
  int           cyc = 0;
  bit           m_busy = 0;
  int           m_cnt = 0;
  bit           m_accept = 0;
  logic [W-1:0] m_sum;
  logic         m_cout;
  int           accept_q[$];
  bit           chk_en = 0;

  always @(posedge clk) begin
    logic [W:0] total;
    cyc++;
    m_accept = 0;
    if (rst) begin
      m_busy = 0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        total = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
        {m_cout, m_sum} = total;
        m_busy   = 1;
        m_cnt    = 0;
        m_accept = 1;
        accept_q.push_back(cyc);
      end
    end else if (m_cnt < N) begin
      m_cnt++;
    end else if (out_ready) begin
      m_busy = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("in_ready", {31'b0, in_ready}, {31'b0, (!m_busy && !rst)});
      check_output("out_valid", {31'b0, out_valid}, {31'b0, (m_busy && m_cnt == N)});
      check_output("busy", {31'b0, busy}, {31'b0, m_busy});
      if (m_busy && m_cnt == N) begin
        check_output("model_sum", {20'b0, out_sum}, {20'b0, m_sum});
        check_output("model_cout", {31'b0, out_cout}, {31'b0, m_cout});
      end
    end
  end

  // Offers one add, waits for its acceptance and result; returns cycles from accept to out_valid
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                input logic rdy, output int lat);
    int t;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1; out_ready = rdy;
    t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (!m_accept && t < 50);
    if (!m_accept) check_output("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_a   = W'($urandom_range(4095, 0));
    in_b   = W'($urandom_range(4095, 0));
    in_cin = 1'($urandom_range(1, 0));
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int t;
    int first;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("rst_busy", {31'b0, busy}, 32'd0);
    check_output("rst_sum", {20'b0, out_sum}, 32'h000);
    check_output("rst_cout", {31'b0, out_cout}, 32'd0);
    rst = 1'b0;
    chk_en = 1;
    #1;
    check_output("idle_in_ready", {31'b0, in_ready}, 32'd1);

    $display("[TB] zero add");
    apply_stimulus(12'h000, 12'h000, 1'b0, 1'b1, lat);
    check_output("t1_latency", lat, 32'd4);
    check_output("t1_sum", {20'b0, out_sum}, 32'h000);
    check_output("t1_cout", {31'b0, out_cout}, 32'd0);
    release_result();

    $display("[TB] full ripple");
    apply_stimulus(12'hFFF, 12'h001, 1'b0, 1'b1, lat);
    check_output("t2_sum", {20'b0, out_sum}, 32'h000);
    check_output("t2_cout", {31'b0, out_cout}, 32'd1);
    release_result();

    $display("[TB] mixed operands");
    apply_stimulus(12'h7A5, 12'h15B, 1'b1, 1'b1, lat);
    check_output("t3a_sum", {20'b0, out_sum}, 32'h901);
    check_output("t3a_cout", {31'b0, out_cout}, 32'd0);
    release_result();
    apply_stimulus(12'hFFF, 12'hFFF, 1'b1, 1'b1, lat);
    check_output("t3b_sum", {20'b0, out_sum}, 32'hFFF);
    check_output("t3b_cout", {31'b0, out_cout}, 32'd1);
    release_result();

    $display("[TB] backpressure");
    apply_stimulus(12'h234, 12'h111, 1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      in_a = W'($urandom_range(4095, 0));
      check_output("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check_output("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check_output("bp_sum", {20'b0, out_sum}, 32'h345);
      check_output("bp_cout", {31'b0, out_cout}, 32'd0);
      check_output("bp_no_accept", {31'b0, m_accept}, 32'd0);
    end
    in_valid = 1'b0;
    release_result();

    $display("[TB] reset mid-run");
    in_a = 12'h0AA; in_b = 12'h011; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check_output("t5_accept", {31'b0, m_accept}, 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_output("t5_rst_in_ready", {31'b0, in_ready}, 32'd0);
    check_output("t5_rst_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_output("t5_post_in_ready", {31'b0, in_ready}, 32'd1);
    check_output("t5_post_busy", {31'b0, busy}, 32'd0);
    apply_stimulus(12'h123, 12'h456, 1'b0, 1'b1, lat);
    check_output("t5_sum", {20'b0, out_sum}, 32'h579);
    check_output("t5_cout", {31'b0, out_cout}, 32'd0);
    release_result();

    $display("[TB] streaming");
    first = accept_q.size();
    in_a = W'($urandom_range(4095, 0));
    in_b = W'($urandom_range(4095, 0));
    in_cin = 1'($urandom_range(1, 0));
    in_valid = 1'b1; out_ready = 1'b1;
    t = 0;
    while (accept_q.size() - first < 20 && t < 400) begin
      @(posedge clk); #1; t++;
      if (m_accept) begin
        in_a = W'($urandom_range(4095, 0));
        in_b = W'($urandom_range(4095, 0));
        in_cin = 1'($urandom_range(1, 0));
      end
    end
    in_valid = 1'b0;
    check_output("t6_accepts", accept_q.size() - first, 32'd20);
    for (int i = first + 1; i < accept_q.size(); i++)
      check_output("t6_spacing", accept_q[i] - accept_q[i-1], 32'd6);
    repeat (8) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation ran too long");
    $fatal(1, "[TB] timeout");
  end
endmodule
